// File: rtl/xcorr_pkg.sv
// -----------------------------------------------------------------------------
// xcorr_pkg
// Shared definitions for the XCORR frame sequencer:
//   - default sample / frame / result / lag widths
//   - derived lag constants (number of lags, index-to-lag offset)
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package xcorr_pkg;

   localparam int XC_W    = 16;    // sample width (signed)
   localparam int XC_N    = 512;   // samples per frame per channel
   localparam int XC_RW   = 32;    // correlator result width (signed)
   localparam int XC_LAGW = 11;    // signed lag width, holds +/-(N-1)

   // A full correlation of two N-sample series yields 2N-1 lags; result
   // index i corresponds to lag i-(N-1).
   localparam int XC_NLAG    = 2 * XC_N - 1;
   localparam int XC_LAG_OFS = XC_N - 1;

   function automatic int nlag(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int lag_ofs(input int n);
      return n - 1;
   endfunction

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_ARM  = 3'd1;
   localparam state_t S_FEED = 3'd2;
   localparam state_t S_WAIT = 3'd3;
   localparam state_t S_DONE = 3'd4;

endpackage

// File: rtl/xcorr_peak_track.sv
// -----------------------------------------------------------------------------
// xcorr_peak_track
// Running maximum / argmax of the correlator results of one frame.
//   clk, rst       : clock, synchronous active-high reset
//   clr_i          : restart tracking (max := most negative, lag := index 0)
//   valid_i        : xc result present this cycle
//   idx_i          : result index (0 .. 2N-2)
//   result_i       : signed result
//   max_next_o     : running max including this cycle's result
//   lag_next_o     : lag (idx-(N-1)) of that max, earliest on ties
// The outputs are the next-state view so the owner can latch the final peak
// in the same cycle the last result arrives.
// -----------------------------------------------------------------------------
module xcorr_peak_track
   import xcorr_pkg::*;
#(
   parameter int RW      = XC_RW,
   parameter int LAGW    = XC_LAGW,
   parameter int IW      = 10,
   parameter int LAG_OFS = XC_LAG_OFS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            valid_i,
   input  logic [IW-1:0]   idx_i,
   input  logic [RW-1:0]   result_i,
   output logic [RW-1:0]   max_next_o,
   output logic [LAGW-1:0] lag_next_o
);

   localparam logic [RW-1:0]   MOST_NEG = {1'b1, {(RW-1){1'b0}}};
   // Lag of index 0: a frame made only of most-negative results reports the
   // earliest index, consistent with the earliest-wins tie rule.
   localparam logic [LAGW-1:0] LAG_IDX0 = LAGW'(-LAG_OFS);

   logic [RW-1:0]   max_q, max_d;
   logic [LAGW-1:0] lag_q, lag_d;
   logic [LAGW-1:0] idx_lag;

   assign idx_lag = LAGW'(idx_i) - LAGW'(LAG_OFS);

   always_comb begin
      max_d = max_q;
      lag_d = lag_q;
      if (clr_i) begin
         max_d = MOST_NEG;
         lag_d = LAG_IDX0;
      end else if (valid_i && ($signed(result_i) > $signed(max_q))) begin
         // strict compare: equal values keep the earlier lag
         max_d = result_i;
         lag_d = idx_lag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         max_q <= MOST_NEG;
         lag_q <= LAG_IDX0;
      end else begin
         max_q <= max_d;
         lag_q <= lag_d;
      end
   end

   assign max_next_o = max_d;
   assign lag_next_o = lag_d;

endmodule

// File: rtl/xcorr_sched.sv
// -----------------------------------------------------------------------------
// xcorr_sched
// Frame sequencer for the XCORR cross-correlation core.
// On frame_rdy: holds xc_start for ARM_CYC cycles, reads N samples per channel
// from the sample buffer into series_x/series_y (zero otherwise), counts the
// 2N-1 returned results and reports the peak lag/value with a done pulse.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   frame_rdy             : new frame available (pulse)
//   rd_en, rd_addr        : buffer read strobe / address
//   rd_x, rd_y            : buffer read data, valid one cycle after rd_en
//   xc_start              : core start/clear level (high = held cleared)
//   series_x, series_y    : sample streams to the core
//   xc_complete, xc_result: core result strobe / signed result
//   busy                  : sequencer not idle
//   done                  : one-cycle pulse, peak outputs refreshed
//   peak_lag, peak_val    : lag and value of the frame maximum
//   overrun               : frame_rdy arrived while busy (frame dropped)
//   err_timeout           : result count short when the frame timer expired
// -----------------------------------------------------------------------------
module xcorr_sched
   import xcorr_pkg::*;
#(
   parameter int W       = XC_W,
   parameter int N       = XC_N,
   parameter int AW      = 9,
   parameter int RW      = XC_RW,
   parameter int LAGW    = XC_LAGW,
   parameter int ARM_CYC = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_rdy,
   output logic            rd_en,
   output logic [AW-1:0]   rd_addr,
   input  logic [W-1:0]    rd_x,
   input  logic [W-1:0]    rd_y,
   output logic            xc_start,
   output logic [W-1:0]    series_x,
   output logic [W-1:0]    series_y,
   input  logic            xc_complete,
   input  logic [RW-1:0]   xc_result,
   output logic            busy,
   output logic            done,
   output logic [LAGW-1:0] peak_lag,
   output logic [RW-1:0]   peak_val,
   output logic            overrun,
   output logic            err_timeout
);

   localparam int NLAG = nlag(N);
   localparam int CW   = $clog2(NLAG + 1);
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam int ACW  = $clog2(ARM_CYC + 1);

   state_t          state_q, state_d;
   logic [ACW-1:0]  arm_cnt_q, arm_cnt_d;
   logic [AW-1:0]   feed_cnt_q, feed_cnt_d;
   logic [CW-1:0]   res_cnt_q, res_cnt_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            err_timeout_q, err_timeout_d;
   logic            rd_en_dly_q;
   logic [W-1:0]    series_x_q, series_y_q;
   logic [LAGW-1:0] peak_lag_q;
   logic [RW-1:0]   peak_val_q;

   logic            in_collect, tmo_hit, res_take, all_res, peak_load;
   logic [RW-1:0]   trk_max;
   logic [LAGW-1:0] trk_lag;

   assign in_collect = (state_q == S_FEED) || (state_q == S_WAIT);
   // The timer counts FEED/WAIT cycles from 0; expiry is decided in the
   // TIMEOUT-th such cycle so the pulse lands TIMEOUT cycles after FEED entry.
   assign tmo_hit    = in_collect && (tmo_cnt_q == TW'(TIMEOUT - 1));
   assign res_take   = in_collect && xc_complete && (res_cnt_q != CW'(NLAG));
   // Look ahead by one result so DONE follows the last result immediately.
   assign all_res    = (res_cnt_q == CW'(NLAG)) ||
                       (res_take && (res_cnt_q == CW'(NLAG - 1)));
   assign peak_load  = (state_q == S_WAIT) && all_res && !tmo_hit;

   always_comb begin
      state_d       = state_q;
      arm_cnt_d     = '0;
      feed_cnt_d    = '0;
      tmo_cnt_d     = '0;
      res_cnt_d     = res_cnt_q;
      err_timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_rdy) state_d = S_ARM;
         end
         S_ARM: begin
            arm_cnt_d = arm_cnt_q + ACW'(1);
            res_cnt_d = '0;
            if (arm_cnt_q == ACW'(ARM_CYC - 1)) state_d = S_FEED;
         end
         S_FEED: begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (feed_cnt_q == AW'(N - 1)) state_d = S_WAIT;
            else feed_cnt_d = feed_cnt_q + AW'(1);
         end
         S_WAIT: begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (all_res) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (res_take) res_cnt_d = res_cnt_q + CW'(1);
      // Expiry overrides any result arriving in the same cycle.
      if (tmo_hit) begin
         state_d       = S_IDLE;
         err_timeout_d = 1'b1;
      end
   end

   xcorr_peak_track #(
      .RW      (RW),
      .LAGW    (LAGW),
      .IW      (CW),
      .LAG_OFS (lag_ofs(N))
   ) u_peak (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (state_q == S_ARM),
      .valid_i    (res_take && !tmo_hit),
      .idx_i      (res_cnt_q),
      .result_i   (xc_result),
      .max_next_o (trk_max),
      .lag_next_o (trk_lag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         arm_cnt_q     <= '0;
         feed_cnt_q    <= '0;
         res_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         err_timeout_q <= 1'b0;
         rd_en_dly_q   <= 1'b0;
         series_x_q    <= '0;
         series_y_q    <= '0;
         peak_lag_q    <= '0;
         peak_val_q    <= '0;
      end else begin
         state_q       <= state_d;
         arm_cnt_q     <= arm_cnt_d;
         feed_cnt_q    <= feed_cnt_d;
         res_cnt_q     <= res_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         err_timeout_q <= err_timeout_d;
         // Buffer data is valid the cycle after the strobe; capture it then
         // and zero-pad every other cycle.
         rd_en_dly_q   <= rd_en;
         series_x_q    <= rd_en_dly_q ? rd_x : '0;
         series_y_q    <= rd_en_dly_q ? rd_y : '0;
         if (peak_load) begin
            peak_lag_q <= trk_lag;
            peak_val_q <= trk_max;
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign xc_start    = (state_q == S_IDLE) || (state_q == S_ARM);
   assign rd_en       = (state_q == S_FEED);
   assign rd_addr     = feed_cnt_q;
   assign series_x    = series_x_q;
   assign series_y    = series_y_q;
   assign peak_lag    = peak_lag_q;
   assign peak_val    = peak_val_q;
   assign err_timeout = err_timeout_q;
   // Dropped frames are flagged combinationally in the cycle they arrive.
   assign overrun     = frame_rdy && busy && !rst;

endmodule
